// File: rtl/reg_wb_queue.sv
// reg_wb_queue: ordered write-back FIFO feeding the register file.
// Merges load and ALU results and forwards pending values to decode.
module reg_wb_queue #(
   parameter int DEPTH = 4,
   parameter int DW    = 32,
   parameter int AW    = 5
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          mem_valid,
   input  logic [AW-1:0] mem_rd,
   input  logic [DW-1:0] mem_data,
   output logic          mem_ready,
   input  logic          alu_valid,
   input  logic [AW-1:0] alu_rd,
   input  logic [DW-1:0] alu_data,
   output logic          alu_ready,
   output logic          Reg_write,
   output logic [AW-1:0] Rd,
   output logic [DW-1:0] write_data,
   input  logic [AW-1:0] fwd_rs1,
   input  logic [AW-1:0] fwd_rs2,
   output logic          fwd_hit1,
   output logic          fwd_hit2,
   output logic [DW-1:0] fwd_data1,
   output logic [DW-1:0] fwd_data2,
   output logic          empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;
   logic [CW-1:0] free;
   logic [PW-1:0] wr_ptr_q;
   logic [PW-1:0] wr_ptr_d;
   logic [PW-1:0] rd_ptr_q;
   logic [PW-1:0] rd_ptr_d;
   logic [PW-1:0] alu_slot;

   logic [AW-1:0] ent_rd_q   [DEPTH];
   logic [DW-1:0] ent_data_q [DEPTH];

   logic          wen_q;
   logic          wen_d;
   logic [AW-1:0] rd_q;
   logic [AW-1:0] rd_d;
   logic [DW-1:0] wd_q;
   logic [DW-1:0] wd_d;

   logic          mem_push;
   logic          alu_push;
   logic          pop;

   // Credit uses registered count only, so a pop never frees a slot early.
   assign free      = CW'(DEPTH) - count_q;
   assign mem_ready = (free >= CW'(1));
   assign mem_push  = mem_valid & mem_ready & (mem_rd != '0);
   assign alu_ready = (free >= (CW'(1) + CW'(mem_push)));
   assign alu_push  = alu_valid & alu_ready & (alu_rd != '0);
   assign pop       = (count_q != '0);

   // Load result is the older instruction, so ALU lands one slot later.
   assign alu_slot = mem_push ? (wr_ptr_q + PW'(1)) : wr_ptr_q;

   assign Reg_write  = wen_q;
   assign Rd         = rd_q;
   assign write_data = wd_q;
   assign empty      = (count_q == '0) & ~wen_q;

   // Next-state for pointers, occupancy and the output stage.
   always_comb begin
      wr_ptr_d = wr_ptr_q + PW'(mem_push) + PW'(alu_push);
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q + CW'(mem_push) + CW'(alu_push) - CW'(pop);
      wen_d    = 1'b0;
      rd_d     = rd_q;
      wd_d     = wd_q;
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
         wen_d    = 1'b1;
         rd_d     = ent_rd_q[rd_ptr_q];
         wd_d     = ent_data_q[rd_ptr_q];
      end
   end

   // Control state and output stage; reset drops every pending entry.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         wen_q    <= 1'b0;
         rd_q     <= '0;
         wd_q     <= '0;
      end else begin
         count_q  <= count_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         wen_q    <= wen_d;
         rd_q     <= rd_d;
         wd_q     <= wd_d;
      end
   end

   // Entry storage; occupancy alone decides which slots are live.
   always_ff @(posedge clk) begin
      if (mem_push) begin
         ent_rd_q[wr_ptr_q]   <= mem_rd;
         ent_data_q[wr_ptr_q] <= mem_data;
      end
      if (alu_push) begin
         ent_rd_q[alu_slot]   <= alu_rd;
         ent_data_q[alu_slot] <= alu_data;
      end
   end

   logic [AW-1:0] lk_rs   [2];
   logic          lk_hit  [2];
   logic [DW-1:0] lk_data [2];

   assign lk_rs[0]  = fwd_rs1;
   assign lk_rs[1]  = fwd_rs2;
   assign fwd_hit1  = lk_hit[0];
   assign fwd_hit2  = lk_hit[1];
   assign fwd_data1 = lk_data[0];
   assign fwd_data2 = lk_data[1];

   for (genvar p = 0; p < 2; p++) begin : g_fwd
      logic [PW-1:0] idx;

      // Scan oldest to youngest so the newest match overrides.
      always_comb begin
         idx        = '0;
         lk_hit[p]  = 1'b0;
         lk_data[p] = '0;
         if (wen_q && (rd_q == lk_rs[p])) begin
            lk_hit[p]  = 1'b1;
            lk_data[p] = wd_q;
         end
         for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr_q + PW'(i);
            if ((CW'(i) < count_q) &&
                (ent_rd_q[idx] == lk_rs[p])) begin
               lk_hit[p]  = 1'b1;
               lk_data[p] = ent_data_q[idx];
            end
         end
         if (lk_rs[p] == '0) begin
            lk_hit[p]  = 1'b0;
            lk_data[p] = '0;
         end
      end
   end

endmodule
